// File: rtl/xc_malu_core.sv
// xc_malu_core: multi-cycle divide/multiply/carry-less/multi-precision arithmetic unit.
// Iterative ops take 32 bit-serial steps; multi-precision add/sub/acc completes on the load edge.
module xc_malu_core (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [31:0] rs3,
   input  logic        flush,
   input  logic        valid,
   input  logic        uop_div,
   input  logic        uop_divu,
   input  logic        uop_rem,
   input  logic        uop_remu,
   input  logic        uop_mul,
   input  logic        uop_mulu,
   input  logic        uop_mulsu,
   input  logic        uop_clmul,
   input  logic        uop_pmul,
   input  logic        uop_pclmul,
   input  logic        uop_madd,
   input  logic        uop_msub,
   input  logic        uop_macc,
   input  logic        uop_mmul,
   input  logic        pw_32,
   input  logic        pw_16,
   input  logic        pw_8,
   input  logic        pw_4,
   input  logic        pw_2,
   output logic [63:0] result,
   output logic        ready
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;
   logic [4:0]  cnt, wm, wm_in;
   logic [31:0] a, b, a_in, b_in, lmask;
   logic [63:0] acc, acc_in, acc_nxt, dv_nxt, mul_nxt, addend, prod, fin, q, r;
   logic [64:0] sh;
   logic [32:0] add33, sub33, rem_t;
   logic        neg, neg_r, op_div, op_divu, op_rem, op_remu, op_smul, is_dv, is_clm;
   logic        dv_in, iter_in, s1, s2, bz;
   assign dv_in   = uop_div | uop_divu | uop_rem | uop_remu;
   assign iter_in = dv_in | uop_mul | uop_mulu | uop_mulsu | uop_clmul | uop_pmul | uop_pclmul | uop_mmul;
   // Signed ops run on magnitudes; the sign is restored on the way out.
   assign s1      = rs1[31] & (uop_div | uop_rem | uop_mul | uop_mulsu);
   assign s2      = rs2[31] & (uop_div | uop_rem | uop_mul);
   assign a_in    = s1 ? -rs1 : rs1;
   assign b_in    = s2 ? -rs2 : rs2;
   assign add33   = {1'b0, rs1} + {1'b0, rs2} + {32'b0, rs3[0]};
   assign sub33   = {1'b0, rs1} - {1'b0, rs2} - {32'b0, rs3[0]};
   assign wm_in   = ((uop_pmul | uop_pclmul) && !pw_32) ?
                    (pw_16 ? 5'd15 : pw_8 ? 5'd7 : pw_4 ? 5'd3 : 5'd1) : 5'd31;
   assign acc_in  = dv_in    ? {32'b0, a_in} :
                    uop_mmul ? {32'b0, rs3} :
                    uop_madd ? {31'b0, add33} :
                    uop_msub ? {31'b0, sub33} :
                    uop_macc ? {rs2, rs1} + {32'b0, rs3} : '0;
   // Restoring division: acc holds {remainder, quotient}.
   assign sh      = {acc, 1'b0};
   assign rem_t   = sh[64:32] - {1'b0, b};
   assign dv_nxt  = (sh[64:32] >= {1'b0, b}) ? {rem_t[31:0], sh[31:1], 1'b1} : sh[63:0];
   // Lane products accumulate unpacked: lane i occupies acc[2W*i +: 2W].
   assign lmask   = (32'hFFFF_FFFF >> (5'd31 - wm)) << (cnt & ~wm);
   assign addend  = {32'b0, a & lmask} << cnt;
   assign mul_nxt = !b[cnt] ? acc : is_clm ? acc ^ addend : acc + addend;
   assign acc_nxt = is_dv ? dv_nxt : mul_nxt;
   always_comb begin
      prod = '0;
      for (int p = 0; p < 32; p++) begin
         prod[p]      = acc[6'(2 * p) - (6'(p) & {1'b0, wm})];
         prod[32 + p] = acc[6'(2 * p) - (6'(p) & {1'b0, wm}) + {1'b0, wm} + 6'd1];
      end
   end
   assign q   = {32'b0, acc[31:0]};
   assign r   = {32'b0, acc[63:32]};
   assign bz  = b == '0;
   assign fin = op_div  ? (bz ? '1 : neg ? -q : q) :
                op_divu ? (bz ? '1 : q) :
                op_rem  ? (bz ? '0 : neg_r ? -r : r) :
                op_remu ? (bz ? '0 : r) :
                (op_smul && neg) ? -prod : prod;
   assign ready  = state == DONE;
   assign result = ready ? fin : '0;
   always_comb begin
      state_nxt = state;
      if (flush)
         state_nxt = IDLE;
      else if (state == IDLE && valid)
         state_nxt = iter_in ? BUSY : DONE;
      else if (state == BUSY)
         state_nxt = !valid ? IDLE : (cnt == 5'd31) ? DONE : BUSY;
   end
   always_ff @(posedge clock or negedge resetn)
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         cnt     <= '0;
         wm      <= '0;
         a       <= '0;
         b       <= '0;
         acc     <= '0;
         neg     <= 1'b0;
         neg_r   <= 1'b0;
         op_div  <= 1'b0;
         op_divu <= 1'b0;
         op_rem  <= 1'b0;
         op_remu <= 1'b0;
         op_smul <= 1'b0;
         is_dv   <= 1'b0;
         is_clm  <= 1'b0;
      end else if (state == IDLE && valid && !flush) begin
         cnt     <= '0;
         wm      <= wm_in;
         a       <= a_in;
         b       <= b_in;
         acc     <= acc_in;
         neg     <= s1 ^ s2;
         neg_r   <= s1;
         op_div  <= uop_div;
         op_divu <= uop_divu;
         op_rem  <= uop_rem;
         op_remu <= uop_remu;
         op_smul <= uop_mul | uop_mulsu;
         is_dv   <= dv_in;
         is_clm  <= uop_clmul | uop_pclmul;
      end else if (state == BUSY) begin
         acc <= acc_nxt;
         cnt <= cnt + 5'd1;
      end
endmodule

// File: tb/tb_xc_malu_core.sv
// tb_xc_malu_core: random and directed checks of xc_malu_core against an arithmetic model.
module tb_xc_malu_core;
   logic        clock = 1'b0, resetn = 1'b0, flush = 1'b0, valid = 1'b0;
   logic [31:0] rs1 = '0, rs2 = '0, rs3 = '0;
   logic [63:0] result;
   logic        ready;
   logic [13:0] uops;
   logic [4:0]  pws;
   int          cur_op = 14, cur_pw = 0;
   int          checks = 0, errors = 0;
   int          m_left = -1;
   logic        m_ready = 1'b0;
   logic [63:0] m_res = '0;
   assign uops = (cur_op < 14) ? 14'(1 << cur_op) : '0;
   assign pws  = 5'(1 << cur_pw);
   always #5 clock = ~clock;
   xc_malu_core dut (
      .clock(clock), .resetn(resetn), .rs1(rs1), .rs2(rs2), .rs3(rs3),
      .flush(flush), .valid(valid),
      .uop_div(uops[0]), .uop_divu(uops[1]), .uop_rem(uops[2]), .uop_remu(uops[3]),
      .uop_mul(uops[4]), .uop_mulu(uops[5]), .uop_mulsu(uops[6]), .uop_clmul(uops[7]),
      .uop_pmul(uops[8]), .uop_pclmul(uops[9]), .uop_madd(uops[10]), .uop_msub(uops[11]),
      .uop_macc(uops[12]), .uop_mmul(uops[13]),
      .pw_32(pws[0]), .pw_16(pws[1]), .pw_8(pws[2]), .pw_4(pws[3]), .pw_2(pws[4]),
      .result(result), .ready(ready)
   );
   function automatic logic [63:0] clm(logic [63:0] x, logic [63:0] y);
      logic [63:0] acc = '0;
      for (int i = 0; i < 64; i++) if (y[i]) acc ^= x << i;
      return acc;
   endfunction
   function automatic bit is_iter(int op);
      return op <= 9 || op == 13;
   endfunction
   function automatic logic [63:0] model(int op, int pwi, logic [31:0] x, logic [31:0] y, logic [31:0] z);
      longint      sx = longint'($signed(x));
      longint      sy = longint'($signed(y));
      logic [63:0] ux = {32'b0, x}, uy = {32'b0, y}, uz = {32'b0, z};
      logic [63:0] res = '0, m, p, la, lb;
      int          w = 32 >> pwi;
      case (op)
         0:  res = (y == 0) ? '1 : 64'(sx / sy);
         1:  res = (y == 0) ? '1 : ux / uy;
         2:  res = (y == 0) ? '0 : 64'(sx % sy);
         3:  res = (y == 0) ? '0 : ux % uy;
         4:  res = 64'(sx * sy);
         5:  res = ux * uy;
         6:  res = 64'(sx * longint'(uy));
         7:  res = clm(ux, uy);
         8, 9: begin
            m = (64'd1 << w) - 1;
            for (int i = 0; i < 32 / w; i++) begin
               la  = (ux >> (i * w)) & m;
               lb  = (uy >> (i * w)) & m;
               p   = (op == 8) ? la * lb : clm(la, lb);
               res |= (p & m) << (i * w);
               res |= ((p >> w) & m) << (32 + i * w);
            end
         end
         10: res = ux + uy + {63'b0, z[0]};
         11: res = {31'b0, (ux < uy + {63'b0, z[0]}), x - y - {31'b0, z[0]}};
         12: res = {y, x} + uz;
         13: res = ux * uy + uz;
         default: res = '0;
      endcase
      return res;
   endfunction
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // Timing model: result due 33 edges (iterative) or 1 edge after load, held until flush.
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_ready = 1'b0;
         m_left  = -1;
      end else if (flush) begin
         m_ready = 1'b0;
         m_left  = -1;
      end else if (!m_ready) begin
         if (m_left < 0) begin
            if (valid) begin
               m_res   = model(cur_op, cur_pw, rs1, rs2, rs3);
               m_left  = is_iter(cur_op) ? 32 : 0;
               m_ready = m_left == 0;
            end
         end else if (!valid) begin
            m_left = -1;
         end else begin
            m_left--;
            m_ready = m_left == 0;
         end
      end
   end
   always @(negedge clock) begin
      chk("ready", {63'b0, ready}, {63'b0, m_ready});
      if (m_ready)
         chk("result", result, m_res);
      else if (!resetn)
         chk("reset_result", result, '0);
   end
   task automatic do_op(int op, int pwi, logic [31:0] x, logic [31:0] y, logic [31:0] z,
                        logic [63:0] lit, bit use_lit, bit scramble);
      int n = 0;
      cur_op = op; cur_pw = pwi; rs1 = x; rs2 = y; rs3 = z;
      valid = 1'b1; flush = 1'b0;
      do begin
         @(posedge clock); #1;
         n++;
         if (scramble) begin rs1 = $urandom; rs2 = $urandom; rs3 = $urandom; end
      end while (!ready && n < 40);
      chk($sformatf("latency op%0d", op), 64'(n), is_iter(op) ? 64'd33 : 64'd1);
      if (use_lit) chk($sformatf("literal op%0d", op), result, lit);
      flush = 1'b1; valid = 1'b0;
      @(posedge clock); #1;
      flush = 1'b0;
      chk("flush_ready", {63'b0, ready}, '0);
   endtask
   function automatic logic [31:0] rnd();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction
   initial begin
      int op, pwi;
      repeat (3) @(posedge clock);
      #1 resetn = 1'b1;
      @(posedge clock); #1;
      do_op(0, 0, 32'hFFFF_FFF9, 32'h2, 0, 64'hFFFF_FFFF_FFFF_FFFD, 1, 0);
      do_op(2, 0, 32'hFFFF_FFF9, 32'h2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
      do_op(1, 0, 32'h1234_5678, 32'h0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
      do_op(3, 0, 32'h1234_5678, 32'h0, 0, 64'h0, 1, 0);
      do_op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 64'h0000_0000_8000_0000, 1, 0);
      do_op(4, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'h0000_0000_0000_0001, 1, 1);
      do_op(5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001, 1, 1);
      do_op(6, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFF_0000_0001, 1, 1);
      do_op(7, 0, 32'h8000_0001, 32'h8000_0001, 0, 64'h4000_0000_0000_0001, 1, 0);
      do_op(8, 1, 32'hFFFF_0003, 32'hFFFF_0005, 0, 64'hFFFE_0000_0001_000F, 1, 0);
      do_op(9, 2, 32'h0303_0303, 32'h0303_0303, 0, 64'h0000_0000_0505_0505, 1, 0);
      do_op(10, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 64'h0000_0001_FFFF_FFFF, 1, 0);
      do_op(11, 0, 32'h0, 32'h1, 32'h0, 64'h0000_0001_FFFF_FFFF, 1, 0);
      do_op(12, 0, 32'hFFFF_FFFF, 32'h1, 32'h1, 64'h0000_0002_0000_0000, 1, 0);
      do_op(13, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1, 0);
      do_op(14, 0, 32'h1234, 32'h5678, 32'h9, 64'h0, 1, 0);
      // Abort: valid drops mid-operation, nothing completes.
      cur_op = 1; rs1 = 32'd100; rs2 = 32'd7; valid = 1'b1;
      repeat (5) @(posedge clock);
      #1 valid = 1'b0;
      repeat (36) @(posedge clock);
      #1 chk("abort_ready", {63'b0, ready}, '0);
      // Asynchronous reset while busy and while done.
      cur_op = 4; rs1 = 32'h7; rs2 = 32'h9; valid = 1'b1;
      repeat (10) @(posedge clock);
      #1 resetn = 1'b0;
      #1 chk("rst_busy_ready", {63'b0, ready}, '0);
      chk("rst_busy_result", result, '0);
      valid = 1'b0;
      @(posedge clock); #1 resetn = 1'b1;
      cur_op = 10; rs1 = 32'h5; rs2 = 32'h6; rs3 = 32'h0; valid = 1'b1;
      @(posedge clock); #1;
      chk("done_ready", {63'b0, ready}, 64'd1);
      chk("done_result", result, 64'd11);
      resetn = 1'b0;
      #1 chk("rst_done_ready", {63'b0, ready}, '0);
      chk("rst_done_result", result, '0);
      valid = 1'b0;
      @(posedge clock); #1 resetn = 1'b1;
      for (int k = 0; k < 1500; k++) begin
         op  = $urandom_range(0, 14);
         pwi = (op == 8 || op == 9) ? $urandom_range(1, 4) : 0;
         do_op(op, pwi, rnd(), rnd(), rnd(), '0, 0, bit'($urandom_range(0, 1)));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
